count_capture_fifo: RTL and testbench

- Downstream consumer of the free-running 4-bit counter.
- On each capture strobe, snapshots the counter value into a small FIFO.
- Drains the FIFO through a valid/ready dequeue port to the next stage (timestamp logger / bus bridge).
- Reports occupancy and a sticky overflow flag for captures lost while full.

---
 rtl/count_capture_fifo_pkg.sv | 17 +
 rtl/count_capture_fifo_sync_fifo_core.sv | 65 ++++++
 rtl/count_capture_fifo.sv | 62 ++++++
 tb/tb_count_capture_fifo.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/count_capture_fifo_pkg.sv
// Shared constants and sizing helpers for the counter capture FIFO.
// WIDTH default is shared with the free-running counter that feeds it.
package count_capture_fifo_pkg;

    localparam int COUNT_WIDTH = 4;
    localparam int CAPTURE_DEPTH = 4;

    function automatic int ptr_width(input int depth);
        return $clog2(depth);
    endfunction

    // One extra bit so the occupancy can represent DEPTH itself.
    function automatic int occ_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/count_capture_fifo_sync_fifo_core.sv
// Synchronous FIFO core: storage, wrapping pointers and an occupancy counter.
// Full/empty come from the occupancy counter so pointers may wrap freely.
module sync_fifo_core
    import count_capture_fifo_pkg::*;
#(
    parameter int WIDTH = COUNT_WIDTH,
    parameter int DEPTH = CAPTURE_DEPTH
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        enq_req,
    input  logic [WIDTH-1:0]            enq_data,
    input  logic                        deq_ready,
    output logic                        deq_valid,
    output logic [WIDTH-1:0]            head_data,
    output logic [occ_width(DEPTH)-1:0] occupancy,
    output logic                        full,
    output logic                        enq_fire,
    output logic                        deq_fire
);

    localparam int PW = ptr_width(DEPTH);
    localparam int OW = occ_width(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    head;
    logic [PW-1:0]    tail;

    // Handshake: a transfer happens on any rising edge where valid and ready
    // are both high; valid never depends on ready, and head data is held
    // stable while valid && !ready. An entry written this cycle is only
    // offered the next cycle (no enqueue-to-dequeue bypass).
    assign full      = (occupancy == OW'(DEPTH));
    assign deq_valid = (occupancy != '0);
    assign deq_fire  = deq_valid && deq_ready;
    assign enq_fire  = enq_req && (!full || deq_fire);
    assign head_data = mem[head];

    always_ff @(posedge clock) begin
        if (enq_fire) begin
            mem[tail] <= enq_data;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            head      <= '0;
            tail      <= '0;
            occupancy <= '0;
        end else begin
            if (enq_fire) begin
                tail <= tail + PW'(1);
            end
            if (deq_fire) begin
                head <= head + PW'(1);
            end
            if (enq_fire && !deq_fire) begin
                occupancy <= occupancy + OW'(1);
            end else if (deq_fire && !enq_fire) begin
                occupancy <= occupancy - OW'(1);
            end
        end
    end

endmodule

// File: rtl/count_capture_fifo.sv
// Captures counter snapshots on a strobe into a FIFO drained via valid/ready,
// with occupancy reporting and a sticky flag for captures lost while full.
module count_capture_fifo
    import count_capture_fifo_pkg::*;
#(
    parameter int WIDTH = COUNT_WIDTH,
    parameter int DEPTH = CAPTURE_DEPTH
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic [WIDTH-1:0]            io_count,
    input  logic                        io_capture,
    input  logic                        io_deq_ready,
    output logic                        io_deq_valid,
    output logic [WIDTH-1:0]            io_deq_bits,
    output logic [occ_width(DEPTH)-1:0] io_entries,
    output logic                        io_overflow,
    input  logic                        io_clear_overflow
);

    logic             deq_valid;
    logic [WIDTH-1:0] head_data;
    logic             full;
    logic             enq_fire;
    logic             deq_fire;
    logic             drop;

    sync_fifo_core #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_core (
        .clock     (clock),
        .reset     (reset),
        .enq_req   (io_capture),
        .enq_data  (io_count),
        .deq_ready (io_deq_ready),
        .deq_valid (deq_valid),
        .head_data (head_data),
        .occupancy (io_entries),
        .full      (full),
        .enq_fire  (enq_fire),
        .deq_fire  (deq_fire)
    );

    // A capture is lost only when full and the head is not leaving this cycle.
    assign drop = io_capture && full && !deq_fire;

    assign io_deq_valid = deq_valid;
    assign io_deq_bits  = deq_valid ? head_data : '0;

    // Setting wins over clearing so a drop in the clear cycle is never missed.
    always_ff @(posedge clock) begin
        if (!reset) begin
            io_overflow <= 1'b0;
        end else if (drop) begin
            io_overflow <= 1'b1;
        end else if (io_clear_overflow) begin
            io_overflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_count_capture_fifo.sv
// Directed test of count_capture_fifo: reset, ordering, overflow, full
// simultaneous enqueue/dequeue, pointer wrap and set-over-clear precedence.
module tb_count_capture_fifo;

    localparam int W  = 4;
    localparam int D  = 4;
    localparam int OW = 3;

    logic          clock = 1'b0;
    logic          reset;
    logic [W-1:0]  io_count;
    logic          io_capture;
    logic          io_deq_ready;
    logic          io_deq_valid;
    logic [W-1:0]  io_deq_bits;
    logic [OW-1:0] io_entries;
    logic          io_overflow;
    logic          io_clear_overflow;

    int total = 0;
    int bad   = 0;

    count_capture_fifo #(
        .WIDTH (W),
        .DEPTH (D)
    ) dut (
        .clock             (clock),
        .reset             (reset),
        .io_count          (io_count),
        .io_capture        (io_capture),
        .io_deq_ready      (io_deq_ready),
        .io_deq_valid      (io_deq_valid),
        .io_deq_bits       (io_deq_bits),
        .io_entries        (io_entries),
        .io_overflow       (io_overflow),
        .io_clear_overflow (io_clear_overflow)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    // Advance one rising edge and settle; inputs change and outputs are sampled here.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("FAIL %s got=%0d exp=%0d", tag, observed, expected);
        end
    endtask

    task automatic capture(input logic [W-1:0] value);
        io_count   = value;
        io_capture = 1'b1;
        tick();
        io_capture = 1'b0;
    endtask

    task automatic fill_1_to_4();
        for (int v = 1; v <= 4; v++) begin
            capture(W'(v));
        end
    endtask

    task automatic drain_expect(input string tag, input logic [W-1:0] e0, input logic [W-1:0] e1,
                                input logic [W-1:0] e2, input logic [W-1:0] e3);
        logic [W-1:0] exp_v [4];
        exp_v = '{e0, e1, e2, e3};
        io_deq_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check({tag, "_valid"}, 32'(io_deq_valid), 32'd1);
            check({tag, "_bits"}, 32'(io_deq_bits), 32'(exp_v[i]));
            tick();
        end
        io_deq_ready = 1'b0;
        check({tag, "_empty_valid"}, 32'(io_deq_valid), 32'd0);
        check({tag, "_empty_entries"}, 32'(io_entries), 32'd0);
    endtask

    initial begin
        reset             = 1'b0;
        io_count          = 4'd7;
        io_capture        = 1'b1;
        io_deq_ready      = 1'b0;
        io_clear_overflow = 1'b0;
        tick();
        tick();
        reset      = 1'b1;
        io_capture = 1'b0;
        check("reset_valid", 32'(io_deq_valid), 32'd0);
        check("reset_entries", 32'(io_entries), 32'd0);
        check("reset_bits", 32'(io_deq_bits), 32'd0);
        check("reset_overflow", 32'(io_overflow), 32'd0);

        // Single capture, then a one-cycle dequeue.
        capture(4'd5);
        check("single_valid", 32'(io_deq_valid), 32'd1);
        check("single_bits", 32'(io_deq_bits), 32'd5);
        check("single_entries", 32'(io_entries), 32'd1);
        tick();
        check("single_hold_bits", 32'(io_deq_bits), 32'd5);
        io_deq_ready = 1'b1;
        tick();
        io_deq_ready = 1'b0;
        check("single_drain_valid", 32'(io_deq_valid), 32'd0);
        check("single_drain_entries", 32'(io_entries), 32'd0);

        // Empty: capture with ready high must not dequeue in the same cycle.
        io_deq_ready = 1'b1;
        capture(4'd6);
        io_deq_ready = 1'b0;
        check("nobypass_entries", 32'(io_entries), 32'd1);
        check("nobypass_bits", 32'(io_deq_bits), 32'd6);
        io_deq_ready = 1'b1;
        tick();
        io_deq_ready = 1'b0;
        check("nobypass_drained", 32'(io_entries), 32'd0);

        // Fill and order.
        fill_1_to_4();
        check("fill_entries", 32'(io_entries), 32'd4);
        check("fill_overflow", 32'(io_overflow), 32'd0);
        drain_expect("fill", 4'd1, 4'd2, 4'd3, 4'd4);

        // Overflow: capture while full with no dequeue drops the value.
        fill_1_to_4();
        capture(4'd9);
        check("ovf_flag", 32'(io_overflow), 32'd1);
        check("ovf_entries", 32'(io_entries), 32'd4);
        drain_expect("ovf", 4'd1, 4'd2, 4'd3, 4'd4);
        check("ovf_sticky", 32'(io_overflow), 32'd1);
        io_clear_overflow = 1'b1;
        tick();
        io_clear_overflow = 1'b0;
        check("ovf_cleared", 32'(io_overflow), 32'd0);

        // Full with simultaneous enqueue and dequeue.
        fill_1_to_4();
        io_deq_ready = 1'b1;
        capture(4'd9);
        io_deq_ready = 1'b0;
        check("simul_entries", 32'(io_entries), 32'd4);
        check("simul_overflow", 32'(io_overflow), 32'd0);
        drain_expect("simul", 4'd2, 4'd3, 4'd4, 4'd9);

        // Ten enqueue/dequeue pairs walk the pointers across the wrap point.
        for (int i = 0; i < 10; i++) begin
            capture(W'(i));
            check("wrap_bits", 32'(io_deq_bits), 32'(i));
            io_deq_ready = 1'b1;
            tick();
            io_deq_ready = 1'b0;
            check("wrap_empty", 32'(io_deq_valid), 32'd0);
        end

        // Drop in the same cycle as clear: the set wins.
        fill_1_to_4();
        io_clear_overflow = 1'b1;
        capture(4'd11);
        io_clear_overflow = 1'b0;
        check("prec_overflow", 32'(io_overflow), 32'd1);
        check("prec_entries", 32'(io_entries), 32'd4);
        io_clear_overflow = 1'b1;
        tick();
        io_clear_overflow = 1'b0;
        check("prec_cleared", 32'(io_overflow), 32'd0);

        // Reset mid-operation discards all entries.
        reset = 1'b0;
        tick();
        reset = 1'b1;
        check("midreset_entries", 32'(io_entries), 32'd0);
        check("midreset_bits", 32'(io_deq_bits), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
